// File: rtl/fetch_unit_if.sv
// Fetch stage bus: ROM request/response, redirect input, and decode handshake.
interface fetch_unit_if #(
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned INSTR_W = 16
);
    logic               start;
    logic               rom_en;
    logic [ADDR_W-1:0]  rom_addr;
    logic [INSTR_W-1:0] rom_data;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_addr;
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;
    logic               busy;
    logic               done;

    // Fetch unit side.
    modport master (
        input  start, rom_data, redirect_valid, redirect_addr, instr_ready,
        output rom_en, rom_addr, instr_valid, instr, instr_pc, busy, done
    );

    // Environment side (ROM, decode, control).
    modport slave (
        output start, rom_data, redirect_valid, redirect_addr, instr_ready,
        input  rom_en, rom_addr, instr_valid, instr, instr_pc, busy, done
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, requests from a registered ROM, captures
// the response into an instruction register and offers it to decode.
module fetch_unit #(
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned INSTR_W  = 16,
    parameter int unsigned PROG_LEN = 9,
    parameter int unsigned WRAP     = 0
) (
    input logic          clk,
    input logic          rst,
    fetch_unit_if.master bus
);
    typedef enum logic [2:0] {StIdle, StReq, StCapt, StHold, StDone} state_e;

    localparam logic [ADDR_W-1:0] LastPc  = ADDR_W'(PROG_LEN - 1);
    // One bit wider so PROG_LEN == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0]   ProgLen = (ADDR_W + 1)'(PROG_LEN);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  pc_next;
    logic               redirect_hit;
    logic               redirect_stop;

    // Sequential successor of the PC, with optional wrap at the program end.
    always_comb begin
        pc_next = pc_q + 1'b1;
        if ((WRAP != 0) && (pc_q == LastPc)) begin
            pc_next = '0;
        end
    end

    // Next-state logic; redirect overrides every other transition while active.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        redirect_hit  = bus.redirect_valid &&
                        ((state_q == StReq) || (state_q == StCapt) || (state_q == StHold));
        redirect_stop = (WRAP == 0) && ({1'b0, bus.redirect_addr} >= ProgLen);

        unique case (state_q)
            StIdle, StDone: begin
                if (bus.start) begin
                    pc_d    = '0;
                    state_d = StReq;
                end
            end
            StReq: state_d = StCapt;
            StCapt: begin
                instr_d    = bus.rom_data;
                instr_pc_d = pc_q;
                pc_d       = pc_next;
                state_d    = StHold;
            end
            StHold: begin
                // pc always equals instr_pc+1 here when not wrapping, so testing
                // the held PC against the last slot also covers PROG_LEN == 2**ADDR_W.
                if (bus.instr_ready) begin
                    state_d = ((WRAP == 0) && (instr_pc_q == LastPc)) ? StDone : StReq;
                end
            end
            default: state_d = StIdle;
        endcase

        if (redirect_hit) begin
            pc_d       = bus.redirect_addr;
            instr_d    = instr_q;     // drop any in-flight capture
            instr_pc_d = instr_pc_q;
            state_d    = redirect_stop ? StDone : StReq;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            pc_q       <= '0;
            instr_q    <= '0;
            instr_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    // Outputs decode directly from the registered state.
    always_comb begin
        bus.rom_en      = (state_q == StReq);
        bus.rom_addr    = pc_q;
        bus.instr_valid = (state_q == StHold);
        bus.instr       = instr_q;
        bus.instr_pc    = instr_pc_q;
        bus.busy        = (state_q == StReq) || (state_q == StCapt) || (state_q == StHold);
        bus.done        = (state_q == StDone);
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed stimulus, a transaction-level reference model
// compared every cycle, and a second wrapping instance checked by handshake order.
module tb_fetch_unit;
    localparam int unsigned AW = 5;
    localparam int unsigned IW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst1 = 1'b1;
    always #5 clk = ~clk;

    fetch_unit_if #(.ADDR_W(AW), .INSTR_W(IW)) bus0 ();
    fetch_unit_if #(.ADDR_W(AW), .INSTR_W(IW)) bus1 ();

    fetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .PROG_LEN(9), .WRAP(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    fetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .PROG_LEN(4), .WRAP(1)) dut1 (
        .clk (clk),
        .rst (rst1),
        .bus (bus1)
    );

    // Program image and registered ROMs.
    logic [15:0] rom [32];
    logic [15:0] rom_q0, rom_q1;
    initial begin
        for (int i = 0; i < 32; i++) rom[i] = 16'hF000 | 16'(i);
        rom[0] = 16'hE805; rom[1] = 16'hEC08; rom[2] = 16'h2A51;
        rom[3] = 16'h31A0; rom[4] = 16'h4C02; rom[5] = 16'h5B17;
        rom[6] = 16'h6E3C; rom[7] = 16'h7F00; rom[8] = 16'h8001;
    end
    always @(posedge clk) begin
        if (bus0.rom_en) rom_q0 <= rom[bus0.rom_addr];
        if (bus1.rom_en) rom_q1 <= rom[bus1.rom_addr];
    end
    assign bus0.rom_data = rom_q0;
    assign bus1.rom_data = rom_q1;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (bus0.instr_valid) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
    endtask

    // Reference model for dut0 (PROG_LEN=9, WRAP=0): mode 0 idle, 1 running,
    // 2 finished; while running, age counts cycles into the current fetch.
    int          m_mode, m_age, m_pc, m_ipc;
    logic [15:0] m_instr;
    bit          m_live = 1'b0;
    always @(posedge clk) begin
        if (rst) begin
            m_mode <= 0; m_age <= 0; m_pc <= 0; m_ipc <= 0; m_instr <= '0; m_live <= 1'b1;
        end else if (m_live) begin
            if (m_mode != 1) begin
                if (bus0.start) begin
                    m_mode <= 1; m_age <= 0; m_pc <= 0;
                end
            end else if (bus0.redirect_valid) begin
                m_pc <= int'(bus0.redirect_addr);
                if (int'(bus0.redirect_addr) >= 9) m_mode <= 2;
                else m_age <= 0;
            end else begin
                case (m_age)
                    0: m_age <= 1;
                    1: begin
                        m_instr <= rom[m_pc];
                        m_ipc   <= m_pc;
                        m_pc    <= (m_pc + 1) % 32;
                        m_age   <= 2;
                    end
                    default: begin
                        if (bus0.instr_ready) begin
                            if (m_pc == 9) m_mode <= 2;
                            else m_age <= 0;
                        end
                    end
                endcase
            end
        end
    end

    // Per-cycle compare of every dut0 output against the model.
    always @(negedge clk) begin
        logic [29:0] act, exp;
        if (m_live) begin
            act = {bus0.rom_en, bus0.instr_valid, bus0.busy, bus0.done,
                   bus0.rom_addr, bus0.instr_pc, bus0.instr};
            exp = {(m_mode == 1 && m_age == 0), (m_mode == 1 && m_age == 2),
                   (m_mode == 1), (m_mode == 2), 5'(m_pc), 5'(m_ipc), m_instr};
            n_assert++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL model_cmp t=%0t: got {en,vld,busy,done,addr,ipc,instr}=0x%0h, expected 0x%0h",
                         $time, act, exp);
            end
        end
    end

    // dut0 handshakes, sampled just before the edge that completes them.
    int hs0 [$];
    always @(posedge clk) begin
        if (!rst && bus0.instr_valid && bus0.instr_ready) hs0.push_back(int'(bus0.instr_pc));
    end

    // dut1 (PROG_LEN=4, WRAP=1): PC sequence 0,1,2,3,0,... and never done.
    int hs1_cnt = 0;
    bit mon1_en = 1'b0;
    always @(posedge clk) begin
        if (mon1_en && bus1.instr_valid && bus1.instr_ready) begin
            check("wrap_pc", 32'(bus1.instr_pc), 32'(hs1_cnt % 4));
            check("wrap_instr", 32'(bus1.instr), 32'(rom[hs1_cnt % 4]));
            hs1_cnt++;
        end
    end
    always @(negedge clk) begin
        if (mon1_en) check("wrap_no_done", 32'(bus1.done), 32'd0);
    end

    initial begin
        bit ok;
        bus0.start = 1'b0; bus0.redirect_valid = 1'b0; bus0.redirect_addr = '0;
        bus0.instr_ready = 1'b0;
        bus1.start = 1'b0; bus1.redirect_valid = 1'b0; bus1.redirect_addr = '0;
        bus1.instr_ready = 1'b1;
        tick(2);
        rst = 1'b0; rst1 = 1'b0; mon1_en = 1'b1;

        // Reset state.
        check("rst_rom_en", 32'(bus0.rom_en), 0);
        check("rst_busy", 32'(bus0.busy), 0);
        check("rst_done", 32'(bus0.done), 0);
        check("rst_valid", 32'(bus0.instr_valid), 0);
        check("rst_instr", 32'(bus0.instr), 0);
        check("rst_ipc", 32'(bus0.instr_pc), 0);

        // 1: full program with ready held high.
        bus0.instr_ready = 1'b1; bus0.start = 1'b1; bus1.start = 1'b1;
        tick(1);
        bus0.start = 1'b0; bus1.start = 1'b0;
        check("t1_req_en", 32'(bus0.rom_en), 1);
        check("t1_req_addr", 32'(bus0.rom_addr), 0);
        tick(1);
        check("t1_capt_busy", 32'(bus0.busy), 1);
        tick(1);
        check("t1_first_valid", 32'(bus0.instr_valid), 1);
        check("t1_first_instr", 32'(bus0.instr), 32'hE805);
        check("t1_first_pc", 32'(bus0.instr_pc), 0);
        tick(3);
        check("t1_second_instr", 32'(bus0.instr), 32'hEC08);
        check("t1_second_pc", 32'(bus0.instr_pc), 1);
        for (int i = 0; i < 60 && !bus0.done; i++) tick(1);
        check("t1_done", 32'(bus0.done), 1);
        check("t1_hs_count", 32'(hs0.size()), 9);
        for (int i = 0; i < hs0.size(); i++) check("t1_hs_order", 32'(hs0[i]), 32'(i));

        // 2: backpressure while holding instr_pc=2.
        bus0.instr_ready = 1'b0; bus0.start = 1'b1;
        tick(1);
        bus0.start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wait_valid(10, ok);
            check("t2_wait_valid", 32'(ok), 1);
            check("t2_pc", 32'(bus0.instr_pc), 32'(k));
            if (k < 2) begin
                bus0.instr_ready = 1'b1; tick(1); bus0.instr_ready = 1'b0;
            end
        end
        for (int c = 0; c < 5; c++) begin
            check("t2_hold_pc", 32'(bus0.instr_pc), 2);
            check("t2_hold_instr", 32'(bus0.instr), 32'h2A51);
            check("t2_hold_rom_en", 32'(bus0.rom_en), 0);
            check("t2_hold_addr", 32'(bus0.rom_addr), 3);
            tick(1);
        end
        bus0.instr_ready = 1'b1;
        tick(3);
        check("t2_next_valid", 32'(bus0.instr_valid), 1);
        check("t2_next_pc", 32'(bus0.instr_pc), 3);
        for (int i = 0; i < 60 && !bus0.done; i++) tick(1);
        check("t2_done", 32'(bus0.done), 1);

        // 3: redirect while holding instr_pc=1, then redirect together with ready.
        bus0.instr_ready = 1'b0; bus0.start = 1'b1;
        tick(1);
        bus0.start = 1'b0;
        wait_valid(10, ok);
        bus0.instr_ready = 1'b1; tick(1); bus0.instr_ready = 1'b0;
        wait_valid(10, ok);
        check("t3_hold_pc1", 32'(bus0.instr_pc), 1);
        bus0.redirect_valid = 1'b1; bus0.redirect_addr = 5'd3;
        tick(1);
        bus0.redirect_valid = 1'b0;
        check("t3_drop_valid", 32'(bus0.instr_valid), 0);
        check("t3_req_addr", 32'(bus0.rom_addr), 3);
        wait_valid(10, ok);
        check("t3_wait_valid", 32'(ok), 1);
        check("t3_target_pc", 32'(bus0.instr_pc), 3);
        check("t3_target_instr", 32'(bus0.instr), 32'h31A0);
        bus0.redirect_valid = 1'b1; bus0.redirect_addr = 5'd7; bus0.instr_ready = 1'b1;
        tick(1);
        bus0.redirect_valid = 1'b0; bus0.instr_ready = 1'b0;
        check("t3_consumed_pc3", 32'(hs0[hs0.size() - 1]), 3);
        wait_valid(10, ok);
        check("t3_second_target", 32'(bus0.instr_pc), 7);
        check("t3_second_instr", 32'(bus0.instr), 32'h7F00);

        // 5: reset in REQ, then in CAPT.
        bus0.instr_ready = 1'b1;
        tick(1);
        check("t5_in_req", 32'(bus0.rom_addr), 8);
        rst = 1'b1; tick(1); rst = 1'b0;
        check("t5_req_rst_instr", 32'(bus0.instr), 0);
        check("t5_req_rst_busy", 32'(bus0.busy), 0);
        check("t5_req_rst_rom_en", 32'(bus0.rom_en), 0);
        tick(3);
        check("t5_req_idle_valid", 32'(bus0.instr_valid), 0);
        bus0.start = 1'b1; tick(1); bus0.start = 1'b0;
        tick(1);
        rst = 1'b1; tick(1); rst = 1'b0;
        check("t5_capt_rst_instr", 32'(bus0.instr), 0);
        check("t5_capt_rst_valid", 32'(bus0.instr_valid), 0);
        tick(3);
        check("t5_capt_idle_instr", 32'(bus0.instr), 0);

        // 6: start while busy, out-of-range redirect, restart from DONE.
        bus0.instr_ready = 1'b0; bus0.start = 1'b1;
        tick(3);
        check("t6_busy_start_pc", 32'(bus0.instr_pc), 0);
        check("t6_busy_start_addr", 32'(bus0.rom_addr), 1);
        tick(1);
        check("t6_still_hold", 32'(bus0.instr_valid), 1);
        bus0.start = 1'b0;
        bus0.redirect_valid = 1'b1; bus0.redirect_addr = 5'd20;
        tick(1);
        check("t6_redir_done", 32'(bus0.done), 1);
        check("t6_redir_busy", 32'(bus0.busy), 0);
        bus0.redirect_addr = 5'd2;
        tick(1);
        bus0.redirect_valid = 1'b0;
        check("t6_done_ignores_redir", 32'(bus0.done), 1);
        bus0.start = 1'b1; tick(1); bus0.start = 1'b0;
        check("t6_restart_addr", 32'(bus0.rom_addr), 0);
        check("t6_restart_en", 32'(bus0.rom_en), 1);
        bus0.instr_ready = 1'b1;
        wait_valid(10, ok);
        check("t6_restart_instr", 32'(bus0.instr), 32'hE805);

        // 4: wrapping instance has been running throughout.
        check("t4_wrap_progress", 32'(hs1_cnt >= 12), 1);

        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
